// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type, port IDs and sizing helper for the memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA = 1'b1;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts ACCESS cycles and flags the last cycle allowed before an abort.
module wait_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic iClk,
  input  logic iRst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = clog2(TIMEOUT);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge iClk) cnt_q <= iRst ? '0 : cnt_d;
  assign expire_o = en_i && cnt_q == W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port between fetch and load/store,
// with registered strobes and a wait-state timeout on every access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iF_Req,
  input  logic [ADDR_W-1:0] iF_Addr,
  output logic [DATA_W-1:0] oF_Data,
  output logic              oF_Ack,
  input  logic              iD_Req,
  input  logic              iD_We,
  input  logic [ADDR_W-1:0] iD_Addr,
  input  logic [DATA_W-1:0] iD_WData,
  output logic [DATA_W-1:0] oD_RData,
  output logic              oD_Ack,
  output logic [ADDR_W-1:0] oMem_Addr,
  output logic [DATA_W-1:0] oMem_WData,
  output logic              oMem_Read,
  output logic              oMem_Write,
  input  logic [DATA_W-1:0] iMem_RData,
  input  logic              iMem_Ack,
  output logic              oBusy,
  output logic              oErr
);
  state_e state_q, state_d;
  logic grant_q, last_q, pick, go, done, expire;
  logic [DATA_W-1:0] rdata;
  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .iClk     (iClk),
    .iRst     (iRst),
    .clr_i    (go),
    .en_i     (state_q == ACCESS),
    .expire_o (expire)
  );
  always_comb begin
    pick = (iF_Req && iD_Req) ? ~last_q : iD_Req;
    go = state_q == IDLE && (iF_Req || iD_Req);
    done = state_q == ACCESS && (iMem_Ack || expire);
    rdata = iMem_Ack ? iMem_RData : ERR_DATA;
    state_d = go ? ACCESS : done ? RESP : state_q == RESP ? IDLE : state_q;
  end
  assign oBusy = state_q != IDLE;
  // The strobe that is still high at completion tells a store from a load.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      grant_q <= PORT_FETCH;
      last_q <= PORT_DATA;
      oMem_Addr <= '0;
      oMem_WData <= '0;
      oMem_Read <= 1'b0;
      oMem_Write <= 1'b0;
      oF_Data <= '0;
      oD_RData <= '0;
      oF_Ack <= 1'b0;
      oD_Ack <= 1'b0;
      oErr <= 1'b0;
    end else begin
      state_q <= state_d;
      oF_Ack <= done && grant_q == PORT_FETCH;
      oD_Ack <= done && grant_q == PORT_DATA;
      if (go) begin
        grant_q <= pick;
        last_q <= pick;
        oMem_Addr <= pick == PORT_DATA ? iD_Addr : iF_Addr;
        if (pick == PORT_DATA) oMem_WData <= iD_WData;
        oMem_Read <= !(pick == PORT_DATA && iD_We);
        oMem_Write <= pick == PORT_DATA && iD_We;
      end
      if (done) begin
        oMem_Read <= 1'b0;
        oMem_Write <= 1'b0;
        if (!iMem_Ack) oErr <= 1'b1;
        if (!oMem_Write && grant_q == PORT_FETCH) oF_Data <= rdata;
        if (!oMem_Write && grant_q == PORT_DATA) oD_RData <= rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with a scoreboard of expected acks checked by a monitor.
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  logic iClk = 0, iRst = 1, iF_Req = 0, iD_Req = 0, iD_We = 0;
  logic [31:0] iF_Addr = 0, iD_Addr = 0, iD_WData = 0, iMem_RData;
  logic [31:0] oF_Data, oD_RData, oMem_Addr, oMem_WData;
  logic oF_Ack, oD_Ack, oMem_Read, oMem_Write, iMem_Ack, oBusy, oErr;
  int checks = 0, errors = 0, cyc = 0, t0 = 0, mcnt = 0, mem_wait = 0;
  logic [31:0] mem_data = 0;
  typedef struct {logic port; logic [31:0] data; int rel; logic err;} exp_t;
  typedef struct {int start; int len; logic wr; logic [31:0] addr; logic [31:0] wdata;} acc_t;
  exp_t exp_q[$];
  exp_t e;
  acc_t acc[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .iClk(iClk), .iRst(iRst),
    .iF_Req(iF_Req), .iF_Addr(iF_Addr), .oF_Data(oF_Data), .oF_Ack(oF_Ack),
    .iD_Req(iD_Req), .iD_We(iD_We), .iD_Addr(iD_Addr), .iD_WData(iD_WData),
    .oD_RData(oD_RData), .oD_Ack(oD_Ack),
    .oMem_Addr(oMem_Addr), .oMem_WData(oMem_WData), .oMem_Read(oMem_Read),
    .oMem_Write(oMem_Write), .iMem_RData(iMem_RData), .iMem_Ack(iMem_Ack),
    .oBusy(oBusy), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  // Memory model: acks after mem_wait strobe cycles; a negative wait never acks.
  always @(posedge iClk) begin
    cyc <= cyc + 1;
    mcnt <= (oMem_Read || oMem_Write) ? mcnt + 1 : 0;
  end
  assign iMem_Ack = (oMem_Read || oMem_Write) && mem_wait >= 0 && mcnt == mem_wait;
  assign iMem_RData = mem_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge iClk) begin
    if (oF_Ack || oD_Ack) begin
      chk("ack_onehot", oF_Ack & oD_Ack, 0);
      if (exp_q.size() == 0) chk("unexpected_ack", {oF_Ack, oD_Ack}, 0);
      else begin
        e = exp_q.pop_front();
        chk("ack_port", oD_Ack, e.port);
        chk("ack_cycle", cyc - t0, e.rel);
        chk("ack_data", e.port ? oD_RData : oF_Data, e.data);
        chk("ack_err", oErr, e.err);
      end
    end
  end

  task automatic push(input logic port, input logic [31:0] data, input int rel, input logic err);
    exp_q.push_back('{port, data, rel, err});
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_data"}, |{oF_Data, oD_RData, oMem_Addr, oMem_WData}, 0);
    chk({n, "_ctl"}, {oF_Ack, oD_Ack, oMem_Read, oMem_Write, oBusy, oErr}, 0);
  endtask

  task automatic do_reset();
    @(posedge iClk);
    #1 iRst = 1; iF_Req = 0; iD_Req = 0;
    @(posedge iClk);
    #1 iRst = 0;
    chk_zero("reset");
  endtask

  task automatic run(input logic f, input logic d, input logic we, input logic [31:0] fa,
                     input logic [31:0] da, input logic [31:0] wd, input int budget);
    logic prev = 0;
    acc_t a;
    @(posedge iClk);
    #1 iF_Req = f; iF_Addr = fa; iD_Req = d; iD_We = we; iD_Addr = da; iD_WData = wd;
    t0 = cyc;
    acc.delete();
    for (int n = 0; n < budget; n++) begin
      @(negedge iClk);
      if ((oMem_Read || oMem_Write) && !prev) acc.push_back('{cyc - t0, 0, oMem_Write, oMem_Addr, oMem_WData});
      if (oMem_Read || oMem_Write) begin
        a = acc.pop_back();
        a.len++;
        acc.push_back(a);
      end
      prev = oMem_Read || oMem_Write;
      if (oF_Ack) iF_Req = 0;
      if (oD_Ack) iD_Req = 0;
      if (!iF_Req && !iD_Req && !oBusy) return;
    end
    chk("run_done", 0, 1);
    iF_Req = 0;
    iD_Req = 0;
  endtask

  task automatic chk_acc(input int i, input int start, input int len, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (i >= acc.size()) chk("acc_missing", i, acc.size());
    else begin
      chk("acc_start", acc[i].start, start);
      chk("acc_len", acc[i].len, len);
      chk("acc_wr", acc[i].wr, wr);
      chk("acc_addr", acc[i].addr, addr);
      chk("acc_wdata", acc[i].wdata, wdata);
    end
  endtask

  initial begin
    do_reset();
    mem_wait = 0; mem_data = 32'h1234_5678;
    push(PORT_FETCH, 32'h1234_5678, 2, 0);
    run(1, 0, 0, 32'h10, 0, 0, 20);
    chk("t1_nacc", acc.size(), 1);
    chk_acc(0, 1, 1, 0, 32'h10, 0);
    chk("t1_err", oErr, 0);

    do_reset();
    mem_data = 32'h1111;
    push(PORT_FETCH, 32'h1111, 2, 0);
    push(PORT_DATA, 0, 5, 0);
    run(1, 1, 1, 32'h30, 32'h20, 32'hAA, 30);
    chk("t2_nacc", acc.size(), 2);
    chk_acc(0, 1, 1, 0, 32'h30, 0);
    chk_acc(1, 4, 1, 1, 32'h20, 32'hAA);
    mem_data = 32'h2222;
    push(PORT_FETCH, 32'h2222, 2, 0);
    push(PORT_DATA, 32'h2222, 5, 0);
    run(1, 1, 0, 32'h40, 32'h44, 32'h55, 30);
    chk_acc(0, 1, 1, 0, 32'h40, 32'hAA);
    chk_acc(1, 4, 1, 0, 32'h44, 32'h55);

    mem_wait = 4; mem_data = 32'hCAFE;
    push(PORT_DATA, 32'hCAFE, 6, 0);
    run(0, 1, 0, 0, 32'h50, 32'h55, 30);
    chk_acc(0, 1, 5, 0, 32'h50, 32'h55);
    chk("t3_fdata_kept", oF_Data, 32'h2222);

    mem_wait = -1;
    push(PORT_DATA, 32'hDEAD_BEEF, 16, 1);
    run(0, 1, 0, 0, 32'h54, 32'h55, 40);
    chk_acc(0, 1, 15, 0, 32'h54, 32'h55);
    chk("t4_err", oErr, 1);
    mem_wait = 0; mem_data = 32'h77;
    push(PORT_FETCH, 32'h77, 2, 1);
    run(1, 0, 0, 32'h58, 0, 0, 20);
    chk("t4_err_sticky", oErr, 1);

    do_reset();
    mem_wait = 14; mem_data = 32'h5A5A;
    push(PORT_FETCH, 32'h5A5A, 16, 0);
    run(1, 0, 0, 32'h5C, 0, 0, 40);
    chk_acc(0, 1, 15, 0, 32'h5C, 0);
    chk("t5_err", oErr, 0);

    mem_wait = -1;
    @(posedge iClk);
    #1 iF_Req = 1; iF_Addr = 32'h60; t0 = cyc;
    repeat (3) @(posedge iClk);
    #1 chk("t6_pre_read", {oMem_Read, oBusy}, 2'b11);
    iRst = 1; iF_Req = 0;
    @(posedge iClk);
    #1 iRst = 0;
    @(negedge iClk);
    chk_zero("t6_midreset");
    repeat (4) @(negedge iClk);
    mem_wait = 0; mem_data = 32'h99;
    push(PORT_FETCH, 32'h99, 2, 0);
    run(1, 0, 0, 32'h64, 0, 0, 20);
    chk_acc(0, 1, 1, 0, 32'h64, 0);

    repeat (2) @(negedge iClk);
    chk("exp_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the processor's single memory port between the instruction-fetch requester and the load/store requester of the control unit. Each requester uses a req/ack handshake. The arbiter serialises accesses with round-robin priority and drives the memory strobes from registered values. It also guards every access with a wait-state timeout. It sits between the control unit's memory read/write requests and the memory model or bus, and its acks form the control unit's ready input.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, maximum cycles in ACCESS without iMem_Ack before abort (1..255)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout
- iClk  in  1  clock; all logic on rising edge
- iRst  in  1  reset; one clock, synchronous, active-high
- iF_Req  in  1  fetch request; held until oF_Ack
- iF_Addr  in  ADDR_W  fetch address; stable while iF_Req
- oF_Data  out  DATA_W  fetched word; valid with oF_Ack, held until next fetch ack
- oF_Ack  out  1  one-cycle completion pulse to fetch
- iD_Req  in  1  data request; held until oD_Ack
- iD_We  in  1  1 = store, 0 = load
- iD_Addr  in  ADDR_W  data address
- iD_WData  in  DATA_W  store data
- oD_RData  out  DATA_W  load data; valid with oD_Ack, held until next data ack
- oD_Ack  out  1  one-cycle completion pulse to data requester
- oMem_Addr  out  ADDR_W  registered memory address
- oMem_WData  out  DATA_W  registered store data
- oMem_Read  out  1  read strobe, level, held until iMem_Ack or timeout
- oMem_Write  out  1  write strobe, level, held until iMem_Ack or timeout
- iMem_RData  in  DATA_W  memory read data, sampled when iMem_Ack=1
- iMem_Ack  in  1  memory completion; may be high in the first ACCESS cycle (zero-wait)
- oBusy  out  1  high in ACCESS and RESP
- oErr  out  1  sticky timeout flag; cleared only by iRst

## Operation
- States are IDLE, ACCESS and RESP. Reset puts the FSM in IDLE with lastGrant = DATA, so fetch wins the first tie.
- In IDLE, requests are sampled.
  - If only one request is present, it wins.
  - If both are present, the one not equal to lastGrant wins.
  - The winner's addr, we and wdata are latched into oMem_* and its ID into grant. lastGrant updates to the winner. Next state is ACCESS.
- Fetch is always a read, and oMem_WData is left unchanged on a fetch grant.
- In ACCESS, oMem_Read = ~we and oMem_Write = we, with the wait counter incrementing each cycle.
  - On iMem_Ack: for a read, iMem_RData is captured into the granted port's data register. Next state is RESP.
  - If the counter reaches TIMEOUT-1 with no ack: ERR_DATA is captured for a read (a store is discarded), oErr is set, and next state is RESP.
  - If ack and timeout occur in the same cycle, the ack wins and oErr is not set.
- In RESP, the granted port's Ack is high for exactly one cycle, the strobes are low, and next state is IDLE.
- Requests are only sampled in IDLE. A request held across the ack cycle is seen again in IDLE and is treated as a new access. Requesters must drop Req in the cycle they observe Ack.
- A requester dropping Req during ACCESS does not abort the access; it still receives its Ack.
- Reset values: all outputs 0, both data registers 0, counter 0, oErr 0. Reset mid-ACCESS drops the strobes on the next edge and the access is lost without an Ack.

## Timing
- Req high in IDLE at cycle 0, then strobes at cycle 1.
- With zero-wait memory (ack at cycle 1), Ack is at cycle 2 and the next sampling is at cycle 3. Minimum access is 3 cycles, so there is one issue every 3 cycles.
- With k wait states, Ack is at cycle 2+k.
- On timeout, the strobes are high for TIMEOUT cycles (cycles 1..TIMEOUT) and Ack is at cycle TIMEOUT+1.
- Back-to-back fetch and data requests alternate strictly, so each is guaranteed service within one other access.
- oMem_Addr and oMem_WData are stable for the whole ACCESS, and change only on a grant in IDLE.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP)
  - port IDs PORT_FETCH=0, PORT_DATA=1
  - the ERR_DATA default
  - the counter width function clog2(TIMEOUT)
- One sub-module, wait_timer, is natural. It takes clr/en/expire, is cleared on grant, enabled in ACCESS, and asserts expire at TIMEOUT-1.
- The top level holds the FSM, the grant/lastGrant logic and the holding registers.

## Test plan
- Reset, then fetch only, iF_Addr=0x10, memory acks at cycle 1 with data 0x1234_5678 -> oMem_Read at cycle 1, oF_Ack at cycle 2, oF_Data=0x1234_5678, oErr=0.
- Both requests at cycle 0, first after reset (iD store 0x20 with data 0xAA) -> fetch is granted first, then the store, with oMem_Write and oMem_WData=0xAA. A further simultaneous pair grants fetch, then data (strict alternation).
- Load with memory acking after 4 wait states, data 0xCAFE -> oMem_Read held for 5 cycles, oD_Ack at cycle 6, and oF_Data unchanged.
- Memory never acks a load -> oMem_Read high for 15 cycles, oD_Ack at cycle 16 with 0xDEAD_BEEF. oErr goes to 1 and stays 1 through later good accesses.
- Memory ack at the timeout cycle (k=14) -> real data is returned and oErr stays 0.
- iRst asserted mid-ACCESS -> the next cycle has strobes low, state IDLE, no Ack and all outputs 0. A later request completes normally.
